// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote tally engine.
package vote_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OPEN = 2'd1,
      SCAN = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int DEF_N_CAND = 4;
   localparam int DEF_CNT_W  = 21;

   function automatic logic is_onehot(input logic [31:0] v);
      return (v != '0) && ((v & (v - 32'd1)) == '0);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && !(&count_q)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/vote_tally.sv
// N-candidate vote tally: open, count, close, sequential winner scan, hold.
// Define LIVE_LEADER_EN to add a registered running leader output.
module vote_tally
   import vote_pkg::*;
#(
   parameter  int N_CAND = DEF_N_CAND,
   parameter  int CNT_W  = DEF_CNT_W,
   localparam int IDX_W  = $clog2(N_CAND)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic [N_CAND-1:0]       vote,
   output logic [N_CAND*CNT_W-1:0] counts,
   output logic [CNT_W-1:0]        total,
   output logic [CNT_W-1:0]        invalid_cnt,
   output logic                    busy,
   output logic                    result_valid,
   output logic [IDX_W-1:0]        winner,
`ifdef LIVE_LEADER_EN
   output logic [IDX_W-1:0]        leader,
   output logic                    leader_tie,
`endif
   output logic                    tie
);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt [N_CAND];
   logic [IDX_W-1:0]        k_q, k_d;
   logic [IDX_W-1:0]        best_idx_q, best_idx_d;
   logic [CNT_W-1:0]        best_q, best_d;
   logic                    tie_q, tie_d;
   logic                    rv_q, rv_d;
   logic                    in_open, clr, v_ok, v_bad, last_k;
   logic [31:0]             vote_ext;

   assign vote_ext = 32'(vote);
   assign in_open  = (state_q == OPEN);
   assign clr      = start && (state_q == IDLE || state_q == DONE);
   assign v_ok     = in_open && is_onehot(vote_ext);
   assign v_bad    = in_open && (vote != '0) && !is_onehot(vote_ext);
   assign last_k   = (k_q == IDX_W'(N_CAND - 1));

   for (genvar i = 0; i < N_CAND; i++) begin : g_cand
      sat_counter #(.W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .clr   (clr),
         .inc   (v_ok && vote[i]),
         .count (cnt[i])
      );
      assign counts[i*CNT_W +: CNT_W] = cnt[i];
   end

   sat_counter #(.W(CNT_W)) u_total (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (v_ok),
      .count (total)
   );

   sat_counter #(.W(CNT_W)) u_invalid (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (v_bad),
      .count (invalid_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         k_q        <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         tie_q      <= 1'b0;
         rv_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         tie_q      <= tie_d;
         rv_q       <= rv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)  state_d = OPEN;
         OPEN:    if (stop)   state_d = SCAN;
         SCAN:    if (last_k) state_d = DONE;
         DONE:    if (start)  state_d = OPEN;
         default: state_d = IDLE;
      endcase
   end

   // Scan compares against the running best; result is registered one
   // cycle after the scan ends so winner/tie are stable when flagged.
   always_comb begin
      k_d        = k_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      tie_d      = tie_q;
      rv_d       = (state_q == DONE) && !start;
      if (clr) begin
         best_d     = '0;
         best_idx_d = '0;
         tie_d      = 1'b0;
      end
      if (state_q == OPEN) k_d = '0;
      if (state_q == SCAN) begin
         k_d = k_q + 1'b1;
         if (k_q == '0) begin
            best_d     = cnt[0];
            best_idx_d = '0;
            tie_d      = 1'b0;
         end else if (cnt[k_q] > best_q) begin
            best_d     = cnt[k_q];
            best_idx_d = k_q;
            tie_d      = 1'b0;
         end else if (cnt[k_q] == best_q) begin
            tie_d = 1'b1;
         end
      end
   end

   assign busy         = (state_q == OPEN) || (state_q == SCAN);
   assign result_valid = rv_q;
   assign winner       = best_idx_q;
   assign tie          = tie_q;

`ifdef LIVE_LEADER_EN
   logic [IDX_W-1:0] lead_q, lead_d, lead_c;
   logic             ltie_q, ltie_d, ltie_c;
   logic [CNT_W-1:0] lmax;

   always_comb begin
      lead_c = '0;
      lmax   = cnt[0];
      ltie_c = 1'b0;
      for (int i = 1; i < N_CAND; i++) begin
         if (cnt[i] > lmax) begin
            lmax   = cnt[i];
            lead_c = IDX_W'(i);
            ltie_c = 1'b0;
         end else if (cnt[i] == lmax) begin
            ltie_c = 1'b1;
         end
      end
      lead_d = in_open ? lead_c : lead_q;
      ltie_d = in_open ? ltie_c : ltie_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lead_q <= '0;
         ltie_q <= 1'b0;
      end else begin
         lead_q <= lead_d;
         ltie_q <= ltie_d;
      end
   end

   assign leader     = lead_q;
   assign leader_tie = ltie_q;
`endif

endmodule
